regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port (`RegWrite`/`wrreg`/`wrdata`) between two writeback sources:
- the in-order pipeline writeback stage (requester 0);
- the multi-cycle execution unit (requester 1, mult/div/long loads).

Fixed priority to the pipeline, with a starvation guard for the multi-cycle unit. Holds a pending-write scoreboard so decode can stall on registers still owed by the multi-cycle unit. Sits between the writeback stage and the register file; the register file's same-cycle write bypass is unchanged.

---
 rtl/mips_wb_pkg.sv | 12 +
 rtl/wb_scoreboard.sv | 37 +++
 rtl/regfile_wb_arbiter.sv | 110 +++++++++++
 tb/tb_regfile_wb_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mips_wb_pkg.sv
// Shared writeback definitions: register-file geometry and arbiter state encoding.
package mips_wb_pkg;
  localparam int REG_W    = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam logic [REG_W-1:0] ZERO_REG = '0;

  typedef enum logic {
    NORMAL  = 1'b0,
    STARVED = 1'b1
  } arb_state_t;
endpackage

// File: rtl/wb_scoreboard.sv
// Pending-write vector for registers still owed by the multi-cycle unit,
// with two same-cycle decode query ports.
module wb_scoreboard
  import mips_wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set,
  input  logic [REG_W-1:0] set_reg,
  input  logic             clr,
  input  logic [REG_W-1:0] clr_reg,
  input  logic [REG_W-1:0] chk_reg1,
  input  logic [REG_W-1:0] chk_reg2,
  output logic             busy1,
  output logic             busy2
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_nxt;

  // Set is applied after clear so a freshly issued op wins over a retiring one.
  always_comb begin
    pending_nxt = pending;
    if (clr) pending_nxt[clr_reg] = 1'b0;
    if (set) pending_nxt[set_reg] = 1'b1;
    pending_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= pending_nxt;
  end

  assign busy1 = pending[chk_reg1] && !(clr && (clr_reg == chk_reg1));
  assign busy2 = pending[chk_reg2] && !(clr && (clr_reg == chk_reg2));

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline has priority, multi-cycle unit is
// promoted after STARVE_LIMIT stalled cycles. Scoreboard built under WB_SCOREBOARD_EN.
module regfile_wb_arbiter
  import mips_wb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wb0_valid,
  input  logic [REG_W-1:0]  wb0_reg,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [REG_W-1:0]  wb1_reg,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  input  logic              sb_set,
  input  logic [REG_W-1:0]  sb_reg,
  input  logic [REG_W-1:0]  chk_reg1,
  input  logic [REG_W-1:0]  chk_reg2,
  output logic              busy1,
  output logic              busy2,
  output logic              RegWrite,
  output logic [REG_W-1:0]  wrreg,
  output logic [DATA_W-1:0] wrdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  arb_state_t state;
  logic [3:0] starve_cnt;
  logic [3:0] starve_cnt_nxt;
  logic       xfer0;
  logic       xfer1;

  always_ff @(posedge CLK) begin
    if (!RST_N) starve_cnt <= '0;
    else        starve_cnt <= starve_cnt_nxt;
  end

  always_comb begin
    state          = (starve_cnt == LIMIT) ? STARVED : NORMAL;
    wb0_ready      = 1'b0;
    wb1_ready      = 1'b0;
    xfer0          = 1'b0;
    xfer1          = 1'b0;
    RegWrite       = 1'b0;
    wrreg          = '0;
    wrdata         = '0;
    starve_cnt_nxt = starve_cnt;

    if (RST_N) begin
      case (state)
        STARVED: begin
          wb1_ready = 1'b1;
          wb0_ready = !wb1_valid;
        end
        default: begin
          wb0_ready = 1'b1;
          wb1_ready = !wb0_valid;
        end
      endcase
    end

    xfer0 = wb0_valid && wb0_ready;
    xfer1 = wb1_valid && wb1_ready;

    // The ready rules make the two transfers mutually exclusive.
    if (xfer1) begin
      wrreg    = wb1_reg;
      wrdata   = wb1_data;
      RegWrite = (wb1_reg != ZERO_REG);
    end else if (xfer0) begin
      wrreg    = wb0_reg;
      wrdata   = wb0_data;
      RegWrite = (wb0_reg != ZERO_REG);
    end

    if (!wb1_valid || xfer1)     starve_cnt_nxt = '0;
    else if (starve_cnt != LIMIT) starve_cnt_nxt = starve_cnt + 4'd1;
  end

`ifdef WB_SCOREBOARD_EN
  logic sb_busy1;
  logic sb_busy2;

  wb_scoreboard u_scoreboard (
    .clk      (CLK),
    .rst_n    (RST_N),
    .set      (sb_set),
    .set_reg  (sb_reg),
    .clr      (xfer1),
    .clr_reg  (wb1_reg),
    .chk_reg1 (chk_reg1),
    .chk_reg2 (chk_reg2),
    .busy1    (sb_busy1),
    .busy2    (sb_busy2)
  );

  assign busy1 = RST_N && sb_busy1;
  assign busy2 = RST_N && sb_busy2;
`else
  logic unused_sb;
  assign unused_sb = ^{sb_set, sb_reg, chk_reg1, chk_reg2};
  assign busy1     = 1'b0;
  assign busy2     = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a small register-file model on the write port.
module tb_regfile_wb_arbiter;

`ifdef WB_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        wb0_valid, wb1_valid, wb0_ready, wb1_ready;
  logic [4:0]  wb0_reg, wb1_reg, sb_reg, chk_reg1, chk_reg2, wrreg;
  logic [31:0] wb0_data, wb1_data, wrdata;
  logic        sb_set, busy1, busy2, RegWrite;
  logic [31:0] rf [32];

  int n_cmp = 0;
  int n_bad = 0;

  regfile_wb_arbiter #(.STARVE_LIMIT(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .wb0_valid(wb0_valid), .wb0_reg(wb0_reg), .wb0_data(wb0_data), .wb0_ready(wb0_ready),
    .wb1_valid(wb1_valid), .wb1_reg(wb1_reg), .wb1_data(wb1_data), .wb1_ready(wb1_ready),
    .sb_set(sb_set), .sb_reg(sb_reg), .chk_reg1(chk_reg1), .chk_reg2(chk_reg2),
    .busy1(busy1), .busy2(busy2),
    .RegWrite(RegWrite), .wrreg(wrreg), .wrdata(wrdata)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) if (RegWrite) rf[wrreg] <= wrdata;

  task automatic idle_inputs();
    wb0_valid = 0; wb0_reg = 0; wb0_data = 0;
    wb1_valid = 0; wb1_reg = 0; wb1_data = 0;
    sb_set = 0; sb_reg = 0; chk_reg1 = 0; chk_reg2 = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RST_N = 0;
    wb0_valid = 1; wb0_reg = 5'd1; wb0_data = 32'h11;
    wb1_valid = 1; wb1_reg = 5'd2; wb1_data = 32'h22;
    #1;
    n_cmp++; if (wb0_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wb0_ready: got %b want 0", wb0_ready); end
    n_cmp++; if (wb1_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wb1_ready: got %b want 0", wb1_ready); end
    n_cmp++; if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL rst_regwrite: got %b want 0", RegWrite); end
    step(); step();
    n_cmp++; if (rf[1] !== 32'h0) begin n_bad++; $display("FAIL rst_no_write: got %h want 0", rf[1]); end
    RST_N = 1;
    idle_inputs();
    #1;
    n_cmp++; if ({RegWrite, wrreg, wrdata} !== 38'h0) begin n_bad++; $display("FAIL idle_outputs: got %b/%h/%h want 0/0/0", RegWrite, wrreg, wrdata); end
  endtask

  task automatic test_single_write();
    wb0_valid = 1; wb0_reg = 5'd5; wb0_data = 32'hA5A5A5A5;
    #1;
    n_cmp++; if (wb0_ready !== 1'b1) begin n_bad++; $display("FAIL single_wb0_ready: got %b want 1", wb0_ready); end
    n_cmp++; if (wb1_ready !== 1'b0) begin n_bad++; $display("FAIL single_wb1_ready: got %b want 0", wb1_ready); end
    n_cmp++; if (RegWrite !== 1'b1) begin n_bad++; $display("FAIL single_regwrite: got %b want 1", RegWrite); end
    n_cmp++; if (wrreg !== 5'd5) begin n_bad++; $display("FAIL single_wrreg: got %0d want 5", wrreg); end
    n_cmp++; if (wrdata !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL single_wrdata: got %h want a5a5a5a5", wrdata); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (rf[5] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL single_rf5: got %h want a5a5a5a5", rf[5]); end
    n_cmp++; if (RegWrite !== 1'b0) begin n_bad++; $display("FAIL single_after_idle: got %b want 0", RegWrite); end
  endtask

  // Both requesters valid every cycle: four pipeline grants, then the multi-cycle unit.
  task automatic test_starvation(input string tag);
    wb1_valid = 1; wb1_reg = 5'd8; wb1_data = 32'hBEEF0008;
    wb0_valid = 1; wb0_reg = 5'd7;
    for (int c = 1; c <= 5; c++) begin
      wb0_data = c;
      #1;
      n_cmp++; if (wb0_ready !== (c <= 4)) begin n_bad++; $display("FAIL %s_wb0_ready_c%0d: got %b want %b", tag, c, wb0_ready, (c <= 4)); end
      n_cmp++; if (wb1_ready !== (c == 5)) begin n_bad++; $display("FAIL %s_wb1_ready_c%0d: got %b want %b", tag, c, wb1_ready, (c == 5)); end
      n_cmp++; if (wrreg !== ((c == 5) ? 5'd8 : 5'd7)) begin n_bad++; $display("FAIL %s_wrreg_c%0d: got %0d want %0d", tag, c, wrreg, (c == 5) ? 8 : 7); end
      step();
    end
    wb0_data = 32'h66;
    #1;
    n_cmp++; if ({wb0_ready, wb1_ready} !== 2'b10) begin n_bad++; $display("FAIL %s_cnt_cleared: got %b want 10", tag, {wb0_ready, wb1_ready}); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (rf[7] !== 32'h66) begin n_bad++; $display("FAIL %s_rf7: got %h want 66", tag, rf[7]); end
    n_cmp++; if (rf[8] !== 32'hBEEF0008) begin n_bad++; $display("FAIL %s_rf8: got %h want beef0008", tag, rf[8]); end
  endtask

  task automatic test_scoreboard();
    sb_set = 1; sb_reg = 5'd9; chk_reg1 = 5'd9; chk_reg2 = 5'd9;
    #1;
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL sb_busy_same_cycle: got %b want 0", busy1); end
    step();
    sb_set = 0;
    #1;
    n_cmp++; if (busy1 !== SB) begin n_bad++; $display("FAIL sb_busy1_set: got %b want %b", busy1, SB); end
    n_cmp++; if (busy2 !== SB) begin n_bad++; $display("FAIL sb_busy2_set: got %b want %b", busy2, SB); end
    wb0_valid = 1; wb0_reg = 5'd9; wb0_data = 32'h1;
    #1;
    n_cmp++; if (busy1 !== SB) begin n_bad++; $display("FAIL sb_wb0_no_mask: got %b want %b", busy1, SB); end
    step();
    wb0_valid = 0;
    #1;
    n_cmp++; if (busy1 !== SB) begin n_bad++; $display("FAIL sb_wb0_no_clear: got %b want %b", busy1, SB); end
    wb1_valid = 1; wb1_reg = 5'd9; wb1_data = 32'h99;
    #1;
    n_cmp++; if ({wb1_ready, RegWrite, wrreg} !== {2'b11, 5'd9}) begin n_bad++; $display("FAIL sb_wb1_commit: got %b%b/%0d want 11/9", wb1_ready, RegWrite, wrreg); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL sb_commit_mask: got %b want 0", busy1); end
    step();
    idle_inputs(); chk_reg1 = 5'd9;
    #1;
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL sb_after_clear: got %b want 0", busy1); end
    n_cmp++; if (rf[9] !== 32'h99) begin n_bad++; $display("FAIL sb_rf9: got %h want 99", rf[9]); end
  endtask

  task automatic test_set_clear_same();
    sb_set = 1; sb_reg = 5'd3; chk_reg1 = 5'd3;
    wb1_valid = 1; wb1_reg = 5'd3; wb1_data = 32'h33;
    #1;
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL setclr_busy_now: got %b want 0", busy1); end
    step();
    idle_inputs(); chk_reg1 = 5'd3;
    #1;
    n_cmp++; if (busy1 !== SB) begin n_bad++; $display("FAIL setclr_set_wins: got %b want %b", busy1, SB); end
    wb1_valid = 1; wb1_reg = 5'd3; wb1_data = 32'h34;
    step();
    idle_inputs(); chk_reg1 = 5'd3;
    #1;
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL setclr_cleared: got %b want 0", busy1); end
  endtask

  task automatic test_zero_reg();
    wb0_valid = 1; wb0_reg = 5'd0; wb0_data = 32'h1;
    sb_set = 1; sb_reg = 5'd0;
    #1;
    n_cmp++; if ({wb0_ready, RegWrite} !== 2'b10) begin n_bad++; $display("FAIL zero_accept: got %b want 10", {wb0_ready, RegWrite}); end
    step();
    idle_inputs();
    #1;
    n_cmp++; if (rf[0] !== 32'h0) begin n_bad++; $display("FAIL zero_rf0: got %h want 0", rf[0]); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL zero_busy: got %b want 0", busy1); end
  endtask

  task automatic test_reset_mid();
    sb_set = 1; sb_reg = 5'd12;
    step();
    sb_set = 0; chk_reg1 = 5'd12;
    wb0_valid = 1; wb0_reg = 5'd10; wb0_data = 32'hA0;
    wb1_valid = 1; wb1_reg = 5'd11; wb1_data = 32'hB0;
    #1;
    n_cmp++; if (busy1 !== SB) begin n_bad++; $display("FAIL rstmid_pending: got %b want %b", busy1, SB); end
    step(); step(); step();
    RST_N = 0;
    #1;
    n_cmp++; if ({wb0_ready, wb1_ready, RegWrite} !== 3'b000) begin n_bad++; $display("FAIL rstmid_forced: got %b want 000", {wb0_ready, wb1_ready, RegWrite}); end
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", busy1); end
    step();
    RST_N = 1;
    #1;
    n_cmp++; if (busy1 !== 1'b0) begin n_bad++; $display("FAIL rstmid_pending_cleared: got %b want 0", busy1); end
    idle_inputs();
    test_starvation("rstmid");
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h0;
    idle_inputs();
    test_reset();
    test_single_write();
    test_starvation("starve");
    test_scoreboard();
    test_set_clear_same();
    test_zero_reg();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
